pattern_gen: RTL
================

// Module: pattern_gen
// PURPOSE
//  Test-pattern generator directly downstream of the video sync generator.
//  Consumes its registered vs/hs/de/x/y/field timing and produces RGB pixels.
//  Delays the sync/enable strobes to stay aligned with the colour data.
//  Output feeds the HDMI transmitter front end.
// PARAMETERS
//  X_BITS      12  width of x_in / h_active
//  Y_BITS      12  y_in / v_active are Y_BITS+1 wide (field bit included)
//  COLOR_BITS   8  bits per colour component
// PORTS
//  clk          in   1             pixel clock
//  reset        in   1             synchronous, active-high
//  vs_in        in   1             vertical sync from sync generator
//  hs_in        in   1             horizontal sync
//  de_in        in   1             active-video enable
//  field_in     in   1             current field (0 when progressive)
//  x_in         in   X_BITS         active-area column
//  y_in         in   Y_BITS+1       active-area row
//  pattern_sel  in   3             requested pattern (quasi-static)
//  h_active     in   X_BITS         active width in pixels
//  v_active     in   Y_BITS+1       active height in lines
//  vs_out       out  1             vs_in delayed 3 cycles
//  hs_out       out  1             hs_in delayed 3 cycles
//  de_out       out  1             de_in delayed 3 cycles
//  r_out/g_out/b_out out COLOR_BITS  pixel colour, 0 when de_out=0
// BEHAVIOUR
//  - Reset: all outputs 0; pipeline regs 0; sel_q=0; mbar_pos=0; bar_w=1.
//  - Latency: fixed 3 cycles, input to all outputs; no stall, no handshake.
//  - Frame start (fs): vs_in rising edge (vs_in=1, vs_d=0) with field_in=0.
//    At fs: sel_q<=pattern_sel; bar_w<=max(h_active>>3,1);
//    mbar_pos<=mbar_pos+4, or 0 if mbar_pos+4>=h_active.
//    pattern_sel changes mid-frame have no effect until the next fs.
//  - Stage 1: register inputs. Colour-bar counter on de_in:
//    de rising -> bar_idx=0, bar_pos=0;
//    else if de: bar_pos==bar_w-1 and bar_idx<7 -> bar_idx++, bar_pos=0;
//    otherwise bar_pos++. bar_idx saturates at 7 (remainder pixels are black).
//  - Stage 2: pattern decode (sel_q):
//    0 black; 1 white (all ones);
//    2 colour bars W,Y,C,G,M,R,B,K by bar_idx (full-scale components);
//    3 grey ramp, R=G=B=x[COLOR_BITS-1:0] (wraps every 2^COLOR_BITS px);
//    4 checkerboard 32x32, white when x[5]^y[5] else black;
//    5 moving bar, white when mbar_pos<=x<mbar_pos+16 else dark grey 0x20<<(COLOR_BITS-8);
//    6 border, white when x==0|x==h_active-1|y==0|y==v_active-1 else black;
//    7 reserved: black.
//  - Stage 3: outputs registered; RGB forced 0 when stage-2 de is 0.
//  - Arithmetic is unsigned. mbar_pos+4 and x+16 use X_BITS+1 bits (no wrap).
//    Comparisons use the raw x_in/y_in (y includes field LSB when interlaced).
//  - Second field of an interlaced frame does not trigger fs, so both fields
//    share pattern and bar position.
//  - Reset mid-frame: outputs 0 next cycle; normal output from first fs after.
//  - Simultaneous fs and de rise: fs updates apply to the following cycle;
//    the current pixel uses the old values.
// STRUCTURE
//  - Package pattern_gen_pkg: pattern codes (PAT_BLACK..PAT_BORDER),
//    8-entry colour-bar RGB table, MBAR_STEP=4, MBAR_WIDTH=16, CHECK_SHIFT=5.
//  - One sub-module bar_counter (de edge detect, bar_pos/bar_idx, bar_w input).
//  - Remaining logic inline: fs detect, sel/mbar latch, decode, delay lines.
// TESTING
//  1. 1280x720p, sel=2 -> bar_w=160; first de_out pixel white (FF,FF,FF);
//     pixel 160 yellow (FF,FF,00); pixel 1279 black.
//  2. h_active=1283, sel=2 -> pixels 1280..1282 black (bar_idx saturates at 7).
//  3. sel 1->4 toggled at mid-frame line 300 -> white until next fs;
//     checker begins on the line after fs. (0,0) black, (32,0) white.
//  4. sel=5 over 3 frames -> bar starts at x=4, 8, 12.
//     h_active=8: positions 4, 0, 4.
//  5. Any pattern: vs/hs/de_out equal inputs delayed exactly 3 cycles;
//     RGB=0 whenever de_out=0.
//  6. Interlaced, sel=5: mbar_pos advances once per two fields.
//     Reset asserted mid-line -> all outputs 0 next cycle.

Source files
------------

// File: rtl/pattern_gen_pkg.sv
// Shared constants for the test-pattern generator: pattern codes, colour-bar
// table and moving-bar / checkerboard geometry.
package pattern_gen_pkg;

    typedef enum logic [2:0] {
        PAT_BLACK    = 3'd0,
        PAT_WHITE    = 3'd1,
        PAT_BARS     = 3'd2,
        PAT_RAMP     = 3'd3,
        PAT_CHECKER  = 3'd4,
        PAT_MBAR     = 3'd5,
        PAT_BORDER   = 3'd6,
        PAT_RESERVED = 3'd7
    } pattern_t;

    localparam int NUM_BARS    = 8;
    localparam int MBAR_STEP   = 4;
    localparam int MBAR_WIDTH  = 16;
    localparam int CHECK_SHIFT = 5;

    // {R,G,B} full-scale enables; entry 0 is the leftmost bar (W,Y,C,G,M,R,B,K)
    localparam logic [NUM_BARS-1:0][2:0] BAR_TABLE = {
        3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
    };

endpackage

// File: rtl/pattern_gen_if.sv
// Video timing in / pixel out bundle between the sync generator side (master)
// and the pattern generator (slave).
interface pattern_gen_if #(
    parameter int X_BITS     = 12,
    parameter int Y_BITS     = 12,
    parameter int COLOR_BITS = 8
);
    logic                  vs_in;
    logic                  hs_in;
    logic                  de_in;
    logic                  field_in;
    logic [X_BITS-1:0]     x_in;
    logic [Y_BITS:0]       y_in;
    logic                  vs_out;
    logic                  hs_out;
    logic                  de_out;
    logic [COLOR_BITS-1:0] r_out;
    logic [COLOR_BITS-1:0] g_out;
    logic [COLOR_BITS-1:0] b_out;

    modport master (
        output vs_in, hs_in, de_in, field_in, x_in, y_in,
        input  vs_out, hs_out, de_out, r_out, g_out, b_out
    );

    modport slave (
        input  vs_in, hs_in, de_in, field_in, x_in, y_in,
        output vs_out, hs_out, de_out, r_out, g_out, b_out
    );
endinterface

// File: rtl/pattern_gen_bar_counter.sv
// Colour-bar position tracker: restarts on each de rising edge and steps the
// bar index every bar_w pixels, holding at the last (black) bar.
module bar_counter
    import pattern_gen_pkg::*;
#(
    parameter int X_BITS = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              de,
    input  logic [X_BITS-1:0] bar_w,
    output logic [2:0]        bar_idx
);
    localparam logic [2:0] LAST_BAR = 3'(NUM_BARS - 1);

    logic              de_d_reg;
    logic [X_BITS-1:0] bar_pos_reg;
    logic [2:0]        bar_idx_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            de_d_reg    <= 1'b0;
            bar_pos_reg <= '0;
            bar_idx_reg <= '0;
        end else begin
            de_d_reg <= de;
            if (de && !de_d_reg) begin
                bar_idx_reg <= '0;
                bar_pos_reg <= '0;
            end else if (de) begin
                if (bar_pos_reg == bar_w - X_BITS'(1) && bar_idx_reg < LAST_BAR) begin
                    bar_idx_reg <= bar_idx_reg + 3'd1;
                    bar_pos_reg <= '0;
                end else begin
                    bar_pos_reg <= bar_pos_reg + X_BITS'(1);
                end
            end
        end
    end

    assign bar_idx = bar_idx_reg;
endmodule

// File: rtl/pattern_gen.sv
// Three-stage test-pattern generator: register timing, decode the pattern,
// register outputs. Pattern, bar width and moving-bar position latch at frame start.
module pattern_gen
    import pattern_gen_pkg::*;
#(
    parameter int X_BITS     = 12,
    parameter int Y_BITS     = 12,
    parameter int COLOR_BITS = 8
) (
    input  logic              clk,
    input  logic              reset,
    pattern_gen_if.slave      vid,
    input  logic [2:0]        pattern_sel,
    input  logic [X_BITS-1:0] h_active,
    input  logic [Y_BITS:0]   v_active
);
    localparam logic [X_BITS:0]       MBAR_STEP_X  = (X_BITS+1)'(MBAR_STEP);
    localparam logic [X_BITS:0]       MBAR_WIDTH_X = (X_BITS+1)'(MBAR_WIDTH);
    localparam logic [COLOR_BITS-1:0] DARK_GREY    = COLOR_BITS'(32'h20 << (COLOR_BITS - 8));

    pattern_t              sel_reg, sel_s1_reg;
    logic [X_BITS-1:0]     mbar_pos_reg, mbar_s1_reg, bar_w_reg;
    logic                  vs_s1_reg, hs_s1_reg, de_s1_reg;
    logic [X_BITS-1:0]     x_s1_reg;
    logic [Y_BITS:0]       y_s1_reg;
    logic                  vs_s2_reg, hs_s2_reg, de_s2_reg;
    logic                  vs_out_reg, hs_out_reg, de_out_reg;
    logic [COLOR_BITS-1:0] pix_out [3];

    logic                  frame_start;
    logic [X_BITS:0]       mbar_sum;
    logic [X_BITS-1:0]     bar_w_next, mbar_next;
    logic [2:0]            bar_idx;
    logic                  mbar_hit, border_hit;
    logic [2:0]            mask_next;
    logic [COLOR_BITS-1:0] level_next;

    // Only the first field's vsync counts, so both fields of a frame match.
    assign frame_start = vid.vs_in & ~vs_s1_reg & ~vid.field_in;
    assign mbar_sum    = {1'b0, mbar_pos_reg} + MBAR_STEP_X;
    assign mbar_next   = (mbar_sum >= {1'b0, h_active}) ? '0 : mbar_sum[X_BITS-1:0];
    assign bar_w_next  = ((h_active >> 3) == '0) ? X_BITS'(1) : (h_active >> 3);

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_reg      <= PAT_BLACK;
            mbar_pos_reg <= '0;
            bar_w_reg    <= X_BITS'(1);
        end else if (frame_start) begin
            sel_reg      <= pattern_t'(pattern_sel);
            mbar_pos_reg <= mbar_next;
            bar_w_reg    <= bar_w_next;
        end
    end

    // Stage 1 carries the frame settings that were in force when the pixel arrived.
    always_ff @(posedge clk) begin
        if (reset) begin
            vs_s1_reg   <= 1'b0;
            hs_s1_reg   <= 1'b0;
            de_s1_reg   <= 1'b0;
            x_s1_reg    <= '0;
            y_s1_reg    <= '0;
            sel_s1_reg  <= PAT_BLACK;
            mbar_s1_reg <= '0;
        end else begin
            vs_s1_reg   <= vid.vs_in;
            hs_s1_reg   <= vid.hs_in;
            de_s1_reg   <= vid.de_in;
            x_s1_reg    <= vid.x_in;
            y_s1_reg    <= vid.y_in;
            sel_s1_reg  <= sel_reg;
            mbar_s1_reg <= mbar_pos_reg;
        end
    end

    bar_counter #(.X_BITS(X_BITS)) u_bar_counter (
        .clk     (clk),
        .reset   (reset),
        .de      (vid.de_in),
        .bar_w   (bar_w_reg),
        .bar_idx (bar_idx)
    );

    assign mbar_hit   = ({1'b0, x_s1_reg} >= {1'b0, mbar_s1_reg}) &&
                        ({1'b0, x_s1_reg} <  {1'b0, mbar_s1_reg} + MBAR_WIDTH_X);
    assign border_hit = (x_s1_reg == '0) || (x_s1_reg == h_active - X_BITS'(1)) ||
                        (y_s1_reg == '0) || (y_s1_reg == v_active - (Y_BITS+1)'(1));

    // Every pattern is a single grey level gated per component by an RGB mask.
    always_comb begin
        mask_next  = 3'b111;
        level_next = '1;
        unique case (sel_s1_reg)
            PAT_WHITE:   mask_next = 3'b111;
            PAT_BARS:    mask_next = BAR_TABLE[bar_idx];
            PAT_RAMP:    level_next = x_s1_reg[COLOR_BITS-1:0];
            PAT_CHECKER: if (!(x_s1_reg[CHECK_SHIFT] ^ y_s1_reg[CHECK_SHIFT])) mask_next = 3'b000;
            PAT_MBAR:    if (!mbar_hit) level_next = DARK_GREY;
            PAT_BORDER:  if (!border_hit) mask_next = 3'b000;
            default:     mask_next = 3'b000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vs_s2_reg  <= 1'b0;
            hs_s2_reg  <= 1'b0;
            de_s2_reg  <= 1'b0;
            vs_out_reg <= 1'b0;
            hs_out_reg <= 1'b0;
            de_out_reg <= 1'b0;
        end else begin
            vs_s2_reg  <= vs_s1_reg;
            hs_s2_reg  <= hs_s1_reg;
            de_s2_reg  <= de_s1_reg;
            vs_out_reg <= vs_s2_reg;
            hs_out_reg <= hs_s2_reg;
            de_out_reg <= de_s2_reg;
        end
    end

    // Component 0 is red, 1 green, 2 blue.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_comp
            logic [COLOR_BITS-1:0] pix_s2_reg;
            logic [COLOR_BITS-1:0] pix_out_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    pix_s2_reg  <= '0;
                    pix_out_reg <= '0;
                end else begin
                    pix_s2_reg  <= mask_next[2-gi] ? level_next : '0;
                    pix_out_reg <= de_s2_reg ? pix_s2_reg : '0;
                end
            end

            assign pix_out[gi] = pix_out_reg;
        end
    endgenerate

    assign vid.vs_out = vs_out_reg;
    assign vid.hs_out = hs_out_reg;
    assign vid.de_out = de_out_reg;
    assign vid.r_out  = pix_out[0];
    assign vid.g_out  = pix_out[1];
    assign vid.b_out  = pix_out[2];
endmodule
